// File: rtl/comp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM state
// encoding and the helpers that size the digit counter from the parameters.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-wide digits in a WIDTH-bit operand (NDIG).
  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter width able to hold the value NDIG itself.
  function automatic int calc_cnt_w(input int ndig);
    return $clog2(ndig + 1);
  endfunction

endpackage

// File: rtl/comp_digit_slice.sv
// Combinational DIGIT-bit magnitude compare cell: the multi-bit form of the
// single-bit l/e/g comparator. Exactly one of lt/eq/gt is high.
module comp_digit_slice #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  // Unsigned compare of one digit; sign handling is done upstream.
  always_comb begin
    lt = (a_d <  b_d);
    eq = (a_d == b_d);
    gt = (a_d >  b_d);
  end

endmodule

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator. Operands are scanned DIGIT bits per clock
// from the MSB down; signed compares are mapped onto the unsigned datapath by
// flipping the operand MSBs (offset binary). Optional early exit on the first
// differing digit. Results l/e/g are registered and held between compares.
module seq_mag_comp
  import comp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             e,
  output logic             g
);

  localparam int               NDIG     = calc_ndig(WIDTH, DIGIT);
  localparam int               CNT_W    = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] NDIG_C   = CNT_W'(NDIG);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CNT_W-1:0] cnt;
  logic             lt_f;
  logic             gt_f;

  logic             d_lt;
  logic             d_eq;
  logic             d_gt;
  logic             hit;
  logic             lt_n;
  logic             gt_n;
  logic             fin;

  comp_digit_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a_d (a_sh[WIDTH-1 -: DIGIT]),
    .b_d (b_sh[WIDTH-1 -: DIGIT]),
    .lt  (d_lt),
    .eq  (d_eq),
    .gt  (d_gt)
  );

  // Merge the current digit into the flags: the first difference wins and
  // later digits are ignored; decide whether this is the final RUN cycle.
  always_comb begin
    hit  = lt_f | gt_f;
    lt_n = hit ? lt_f : d_lt;
    gt_n = hit ? gt_f : d_gt;
    fin  = (cnt == ONE_C) || ((EARLY_EXIT != 0) && !d_eq);
  end

  // FSM, operand shift registers, digit counter and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      l     <= 1'b0;
      e     <= 1'b0;
      g     <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      lt_f  <= 1'b0;
      gt_f  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a ^ (signed_mode ? MSB_MASK : '0);
            b_sh  <= b ^ (signed_mode ? MSB_MASK : '0);
            cnt   <= NDIG_C;
            lt_f  <= 1'b0;
            gt_f  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh <= a_sh << DIGIT;
          b_sh <= b_sh << DIGIT;
          cnt  <= cnt - ONE_C;
          lt_f <= lt_n;
          gt_f <= gt_n;
          if (fin) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            l     <= lt_n;
            g     <= gt_n;
            e     <= ~(lt_n | gt_n);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_comp.sv
// Bench for seq_mag_comp: two instances (early exit on / off) share clock and
// reset. A driver issues compares and queues expected results computed from
// integer arithmetic; a monitor checks every cycle against the queues.
module tb_seq_mag_comp;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int ND = W / D;

  typedef struct {
    logic [2:0] leg;
    int         t0;
    int         dc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  int   cyc = 0;

  logic         start_i [2];
  logic         sm_i    [2];
  logic [W-1:0] a_i     [2];
  logic [W-1:0] b_i     [2];
  logic         busy_o  [2];
  logic         done_o  [2];
  logic         l_o     [2];
  logic         e_o     [2];
  logic         g_o     [2];

  exp_t       q      [2][$];
  int         free_c [2];
  logic [2:0] last   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  seq_mag_comp #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start_i[0]), .signed_mode(sm_i[0]),
    .a(a_i[0]), .b(b_i[0]), .busy(busy_o[0]), .done(done_o[0]),
    .l(l_o[0]), .e(e_o[0]), .g(g_o[0])
  );

  seq_mag_comp #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .signed_mode(sm_i[1]),
    .a(a_i[1]), .b(b_i[1]), .busy(busy_o[1]), .done(done_o[1]),
    .l(l_o[1]), .e(e_o[1]), .g(g_o[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: ordering from plain integer compare; latency from the index of
  // the first differing digit (flipping both MSBs never changes digit equality).
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic sm, input bit ee,
                                output logic [2:0] leg, output int k);
    int ia;
    int ib;
    bit found;
    if (sm) begin
      ia = int'($signed(av));
      ib = int'($signed(bv));
    end else begin
      ia = int'(av);
      ib = int'(bv);
    end
    if (ia < ib)       leg = 3'b100;
    else if (ia == ib) leg = 3'b010;
    else               leg = 3'b001;
    k = ND;
    found = 1'b0;
    if (ee) begin
      for (int i = 0; i < ND; i++) begin
        int sh;
        sh = W - D * (i + 1);
        if (!found && (((int'(av) >> sh) & 3) != ((int'(bv) >> sh) & 3))) begin
          k = i + 1;
          found = 1'b1;
        end
      end
    end
  endfunction

  task automatic issue(input int i, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sm);
    exp_t       ent;
    logic [2:0] leg;
    int         k;
    @(posedge clk); #1;
    while (cyc < free_c[i]) begin
      @(posedge clk); #1;
    end
    model(av, bv, sm, (i == 1), leg, k);
    a_i[i] = av; b_i[i] = bv; sm_i[i] = sm; start_i[i] = 1'b1;
    ent.leg = leg;
    ent.t0  = cyc + 1;
    ent.dc  = cyc + 1 + k;
    q[i].push_back(ent);
    free_c[i] = ent.dc;
    @(posedge clk); #1;
    start_i[i] = 1'b0;
  endtask

  task automatic rand_issue(input int i);
    logic [W-1:0] av;
    logic [W-1:0] bv;
    int           r;
    av = W'($urandom);
    r  = $urandom_range(0, 3);
    if (r == 0)      bv = av;
    else if (r == 1) bv = av ^ (W'(1) << $urandom_range(0, W - 1));
    else             bv = W'($urandom);
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
    issue(i, av, bv, 1'($urandom_range(0, 1)));
  endtask

  // Monitor: reset values, busy window, done timing, l/e/g value and hold.
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        exp_t ent;
        logic eb;
        if (rst_q) begin
          chk($sformatf("rst_busy%0d", i), busy_o[i], 0);
          chk($sformatf("rst_done%0d", i), done_o[i], 0);
          chk($sformatf("rst_leg%0d", i), {l_o[i], e_o[i], g_o[i]}, 0);
          last[i] = 3'b000;
        end else begin
          eb = (q[i].size() > 0) && (cyc >= q[i][0].t0) && (cyc < q[i][0].dc);
          chk($sformatf("busy%0d", i), busy_o[i], eb);
          if (done_o[i] === 1'b1) begin
            if (q[i].size() == 0) begin
              chk($sformatf("unexpected_done%0d", i), 1, 0);
            end else begin
              ent = q[i].pop_front();
              chk($sformatf("leg%0d", i), {l_o[i], e_o[i], g_o[i]}, ent.leg);
              chk($sformatf("done_cycle%0d", i), cyc, ent.dc);
              last[i] = ent.leg;
            end
          end else begin
            chk($sformatf("done_low%0d", i), done_o[i], 0);
            chk($sformatf("hold_leg%0d", i), {l_o[i], e_o[i], g_o[i]}, last[i]);
            if (q[i].size() > 0 && cyc >= q[i][0].dc) begin
              chk($sformatf("missing_done%0d", i), 0, 1);
              void'(q[i].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0; sm_i[i] = 1'b0; a_i[i] = '0; b_i[i] = '0;
      free_c[i] = 0; last[i] = 3'b000;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Early-exit directed cases, the last two back to back.
    issue(1, 8'h5A, 8'h5A, 1'b0);
    issue(1, 8'h80, 8'h7F, 1'b0);
    issue(1, 8'h80, 8'h7F, 1'b1);
    issue(1, 8'h12, 8'h13, 1'b0);
    issue(1, 8'hFF, 8'h00, 1'b0);

    // Fixed latency; a start while busy must be ignored.
    issue(0, 8'hC0, 8'h00, 1'b0);
    @(posedge clk); #1;
    a_i[0] = 8'h00; b_i[0] = 8'hFF; sm_i[0] = 1'b1; start_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;

    for (int n = 0; n < 150; n++) rand_issue(1);
    for (int n = 0; n < 60; n++)  rand_issue(0);

    // Abort a compare with reset two cycles after start.
    @(posedge clk); #1;
    while (cyc < free_c[0] || cyc < free_c[1]) begin
      @(posedge clk); #1;
    end
    issue(1, 8'h12, 8'h13, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q[1].delete();
    free_c[1] = 0;
    repeat (8) @(posedge clk);

    for (int n = 0; n < 10; n++) rand_issue(1);

    @(posedge clk); #1;
    while (cyc < free_c[0] + 3 || cyc < free_c[1] + 3) begin
      @(posedge clk); #1;
    end
    chk("queues_drained", q[0].size() + q[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mag_comp.md
# seq_mag_comp

Parametrised, multi-cycle magnitude comparator: the successor to our single-bit l/e/g comparator cells. It compares two WIDTH-bit operands, unsigned or two's-complement, DIGIT bits per clock from the MSB down, and can terminate early on the first differing digit. It sits behind control logic that needs wide compares without a long combinational chain, and uses a start/busy/done handshake.

## Interface
- WIDTH, 8: operand width in bits; must be a multiple of DIGIT.
- DIGIT, 2: bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.
- EARLY_EXIT, 1: 1 = finish on the first unequal digit; 0 = always run all digits (fixed latency).
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a compare; sampled only when busy=0.
- signed_mode  in  1  1 = two's-complement compare; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse; l/e/g are valid from this cycle on.
- l  out  1  registered A<B.
- e  out  1  registered A==B.
- g  out  1  registered A>B.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE or DONE, with start=1 → RUN:
  - Capture a and b into shift registers.
  - If signed_mode=1, invert the MSB of both captured operands (offset-binary), so the unsigned datapath yields the signed result.
  - Load the digit counter with NDIG = WIDTH/DIGIT. Clear the internal lt/gt flags.
- RUN, each cycle:
  - comp_digit_slice compares the top DIGIT bits of each operand.
  - If the digits differ, set lt or gt. With EARLY_EXIT=1, go to DONE on this edge.
  - If the digits are equal, shift both registers left by DIGIT and decrement the counter.
  - When the last digit has been processed, go to DONE.
  - With EARLY_EXIT=0, the first difference is latched, later digits are ignored, and all NDIG digits are still processed.
- On the edge entering DONE, register l/e/g:
  - Exactly one of them is 1.
  - e=1 only if no digit differed.
- DONE lasts one cycle with done=1. It returns to IDLE, or back to RUN if start=1.
- l/e/g hold their value until the next entry into DONE. They do not change while a new compare is running.
- start while busy=1 is ignored. No queueing.

## Timing
- Reset values: busy=0, done=0, l=0, e=0, g=0, state IDLE, internal registers cleared.
- A reset asserted mid-operation aborts the compare, discards the operands and produces no done pulse. All outputs match the reset values in the cycle after the reset edge.
- busy=1 in every cycle the state is RUN.
- Latency: start sampled at edge t0; done is high in the cycle after edge tk.
  - k = NDIG when the operands are equal, or when EARLY_EXIT=0.
  - k = index (1-based, from the MSB digit) of the first differing digit when EARLY_EXIT=1.
- Back-to-back operation: start=1 in the done cycle is accepted. Throughput is one compare per k+1 cycles.
- No combinational path from any input to any output.

## Structure
- Shared package comp_pkg:
  - state encoding (IDLE, RUN, DONE);
  - localparam NDIG = WIDTH/DIGIT;
  - counter width $clog2(NDIG+1).
- Sub-module comp_digit_slice #(DIGIT): purely combinational. Inputs a_d, b_d; outputs lt, eq, gt. It is the DIGIT-bit generalisation of the 1-bit l/e/g cell.
- Top level: FSM, operand shift registers, digit counter, result registers.

## Test plan
Bench configuration: WIDTH=8, DIGIT=2, EARLY_EXIT=1 unless stated.
- a=8'h5A, b=8'h5A, unsigned → done 4 cycles after start; e=1, l=0, g=0.
- a=8'h80, b=8'h7F, unsigned → done 1 cycle after start (MSB digit 10 vs 01); g=1.
- a=8'h80, b=8'h7F, signed_mode=1 → done after 1 cycle; l=1 (−128 < 127).
- a=8'h12, b=8'h13 → done after 4 cycles; l=1. Then issue a second start in the done cycle with a=8'hFF, b=8'h00 → accepted; g=1 one cycle later.
- EARLY_EXIT=0, a=8'hC0, b=8'h00 → done after 4 cycles; g=1. A start pulse at cycle 2 is ignored (no extra done pulse).
- Start a=8'h12, b=8'h13, then assert rst at cycle 2 → next cycle busy=0, done=0, l=e=g=0. No done pulse ever appears for the aborted compare.
